// File: rtl/vend_transaction_sequencer.sv
// Vending transaction sequencer: coin credit accumulation, price check, timed
// dispense indication and largest-first change payout advanced by the tick enable.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | no credit held, waiting for a coin
// COLLECT  | credit held, accepting coins / vend / cancel, timeout running
// DISPENSE | led_vend shows the product for DISP_TICKS ticks
// CHANGE   | paying out remaining credit, one coin per tick
module vend_transaction_sequencer #(
   parameter int unsigned PRICE0        = 15,
   parameter int unsigned PRICE1        = 20,
   parameter int unsigned PRICE2        = 25,
   parameter int unsigned PRICE3        = 30,
   parameter int unsigned MAX_CREDIT    = 95,
   parameter int unsigned DISP_TICKS    = 3,
   parameter int unsigned TIMEOUT_TICKS = 500
) (
   input  logic       clk,
   input  logic       clr,
   input  logic       tick,
   input  logic       coin_valid,
   input  logic [1:0] coin_type,
   input  logic [3:0] sel,
   input  logic       vend_req,
   input  logic       cancel,
   output logic [7:0] credit,
   output logic [3:0] led_vend,
   output logic [1:0] coin_out,
   output logic       coin_reject,
   output logic       deny,
   output logic       busy
);

   localparam int TMO_W = $clog2(TIMEOUT_TICKS) + 1;
   localparam int DSP_W = $clog2(DISP_TICKS) + 1;

   typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DISPENSE, S_CHANGE} state_t;

   state_t           state, state_nxt;
   logic [7:0]       credit_nxt;
   logic [3:0]       led_nxt;
   logic [1:0]       coin_out_nxt;
   logic             reject_nxt, deny_nxt;
   logic [TMO_W-1:0] tmo_cnt, tmo_nxt;
   logic [DSP_W-1:0] dsp_cnt, dsp_nxt;

   logic [7:0] coin_val;
   logic [8:0] coin_sum;
   logic       coin_ok;
   logic [7:0] price;
   logic       sel_ok;
   logic       coin_acc;
   logic       leaving;

   always_comb begin
      coin_val = 8'd0;
      case (coin_type)
         2'b00:   coin_val = 8'd5;
         2'b01:   coin_val = 8'd10;
         2'b10:   coin_val = 8'd25;
         default: coin_val = 8'd0;
      endcase
      coin_sum = {1'b0, credit} + {1'b0, coin_val};
      coin_ok  = (coin_type != 2'b11) && (coin_sum <= 9'(MAX_CREDIT));
   end

   always_comb begin
      price  = 8'd0;
      sel_ok = 1'b1;
      case (sel)
         4'b0001: price = 8'(PRICE0);
         4'b0010: price = 8'(PRICE1);
         4'b0100: price = 8'(PRICE2);
         4'b1000: price = 8'(PRICE3);
         default: sel_ok = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!clr) begin
         state       <= S_IDLE;
         credit      <= 8'd0;
         led_vend    <= 4'd0;
         coin_out    <= 2'd0;
         coin_reject <= 1'b0;
         deny        <= 1'b0;
         tmo_cnt     <= '0;
         dsp_cnt     <= '0;
      end else begin
         state       <= state_nxt;
         credit      <= credit_nxt;
         led_vend    <= led_nxt;
         coin_out    <= coin_out_nxt;
         coin_reject <= reject_nxt;
         deny        <= deny_nxt;
         tmo_cnt     <= tmo_nxt;
         dsp_cnt     <= dsp_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      credit_nxt   = credit;
      led_nxt      = led_vend;
      coin_out_nxt = 2'b00;
      reject_nxt   = 1'b0;
      deny_nxt     = 1'b0;
      tmo_nxt      = tmo_cnt;
      dsp_nxt      = dsp_cnt;
      coin_acc     = 1'b0;
      leaving      = 1'b0;
      case (state)
         S_IDLE, S_COLLECT: begin
            // cancel outranks vend which outranks coin; a losing coin is returned
            if (cancel) begin
               reject_nxt = coin_valid;
               if (state == S_COLLECT) begin
                  state_nxt = S_CHANGE;
                  leaving   = 1'b1;
               end
            end else if (vend_req) begin
               reject_nxt = coin_valid;
               if (!sel_ok || (credit < price)) begin
                  deny_nxt = 1'b1;
               end else begin
                  credit_nxt = credit - price;
                  led_nxt    = sel;
                  dsp_nxt    = DSP_W'(DISP_TICKS - 1);
                  state_nxt  = S_DISPENSE;
                  leaving    = 1'b1;
               end
            end else if (coin_valid) begin
               if (coin_ok) begin
                  credit_nxt = coin_sum[7:0];
                  state_nxt  = S_COLLECT;
                  tmo_nxt    = TMO_W'(TIMEOUT_TICKS - 1);
                  coin_acc   = 1'b1;
               end else begin
                  reject_nxt = 1'b1;
               end
            end
            if ((state == S_COLLECT) && tick && !coin_acc && !leaving) begin
               if (tmo_cnt == '0)
                  state_nxt = S_CHANGE;
               else
                  tmo_nxt = tmo_cnt - TMO_W'(1);
            end
         end
         S_DISPENSE: begin
            reject_nxt = coin_valid;
            if (tick) begin
               if (dsp_cnt == '0) begin
                  led_nxt   = 4'd0;
                  state_nxt = (credit != 8'd0) ? S_CHANGE : S_IDLE;
               end else begin
                  dsp_nxt = dsp_cnt - DSP_W'(1);
               end
            end
         end
         S_CHANGE: begin
            reject_nxt = coin_valid;
            if (credit == 8'd0) begin
               state_nxt = S_IDLE;
            end else if (tick) begin
               if (credit >= 8'd25) begin
                  coin_out_nxt = 2'b11;
                  credit_nxt   = credit - 8'd25;
               end else if (credit >= 8'd10) begin
                  coin_out_nxt = 2'b10;
                  credit_nxt   = credit - 8'd10;
               end else begin
                  coin_out_nxt = 2'b01;
                  credit_nxt   = (credit > 8'd5) ? credit - 8'd5 : 8'd0;
               end
               if (credit_nxt == 8'd0)
                  state_nxt = S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      busy = (state == S_DISPENSE) || (state == S_CHANGE);
   end

endmodule

// File: tb/tb_vend_transaction_sequencer.sv
// Bench for vend_transaction_sequencer: directed scenarios and random traffic,
// every cycle compared against a transaction-level model of the vending rules.
module tb_vend_transaction_sequencer;

   logic       clk = 1'b0;
   logic       clr = 1'b0;
   logic       tick = 1'b0;
   logic       coin_valid = 1'b0;
   logic [1:0] coin_type = 2'b00;
   logic [3:0] sel = 4'b0001;
   logic       vend_req = 1'b0;
   logic       cancel = 1'b0;
   logic [7:0] credit;
   logic [3:0] led_vend;
   logic [1:0] coin_out;
   logic       coin_reject;
   logic       deny;
   logic       busy;

   vend_transaction_sequencer dut (
      .clk(clk), .clr(clr), .tick(tick), .coin_valid(coin_valid),
      .coin_type(coin_type), .sel(sel), .vend_req(vend_req), .cancel(cancel),
      .credit(credit), .led_vend(led_vend), .coin_out(coin_out),
      .coin_reject(coin_reject), .deny(deny), .busy(busy)
   );

   always #5 clk = ~clk;

   localparam int M_IDLE = 0, M_COLLECT = 1, M_DISP = 2, M_CHANGE = 3;
   int prices[4] = '{15, 20, 25, 30};

   int       m_credit, m_coin, m_mode, m_idle, m_disp;
   logic [3:0] m_led;
   bit       m_reject, m_deny;

   int n_pass = 0, n_total = 0;
   int pay_seq;
   logic [3:0] led_seen;

   function automatic int cents(input int code);
      case (code)
         1: return 5;
         2: return 10;
         3: return 25;
         default: return 0;
      endcase
   endfunction

   function automatic int code_of(input int c);
      case (c)
         5: return 1;
         10: return 2;
         25: return 3;
         default: return 0;
      endcase
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
   endtask

   task automatic model_update();
      int val, p;
      bit accepted;
      m_coin = 0; m_reject = 0; m_deny = 0;
      if (!clr) begin
         m_credit = 0; m_led = 0; m_mode = M_IDLE; m_idle = 0; m_disp = 0;
         return;
      end
      accepted = 0;
      case (m_mode)
         M_IDLE, M_COLLECT: begin
            if (cancel) begin
               m_reject = coin_valid;
               if (m_mode == M_COLLECT) m_mode = M_CHANGE;
            end else if (vend_req) begin
               m_reject = coin_valid;
               p = 0;
               for (int i = 0; i < 4; i++) if (sel[i]) p = prices[i];
               if ($countones(sel) != 1 || m_credit < p) m_deny = 1;
               else begin
                  m_credit -= p; m_led = sel; m_disp = 0; m_mode = M_DISP;
               end
            end else if (coin_valid) begin
               val = cents(int'(coin_type) + 1);
               if (coin_type == 2'b11 || m_credit + val > 95) m_reject = 1;
               else begin
                  m_credit += val; m_mode = M_COLLECT; m_idle = 0; accepted = 1;
               end
            end
            if (m_mode == M_COLLECT && tick && !accepted) begin
               m_idle++;
               if (m_idle == 500) m_mode = M_CHANGE;
            end
         end
         M_DISP: begin
            m_reject = coin_valid;
            if (tick) begin
               m_disp++;
               if (m_disp == 3) begin
                  m_led = 0;
                  m_mode = (m_credit > 0) ? M_CHANGE : M_IDLE;
               end
            end
         end
         default: begin
            m_reject = coin_valid;
            if (tick && m_credit > 0) begin
               m_coin = (m_credit >= 25) ? 25 : (m_credit >= 10) ? 10 : 5;
               m_credit -= m_coin;
               if (m_credit == 0) m_mode = M_IDLE;
            end
         end
      endcase
   endtask

   task automatic compare_all();
      chk("credit", credit, m_credit);
      chk("led_vend", led_vend, m_led);
      chk("coin_out", coin_out, code_of(m_coin));
      chk("coin_reject", coin_reject, m_reject);
      chk("deny", deny, m_deny);
      chk("busy", busy, (m_mode == M_DISP || m_mode == M_CHANGE));
   endtask

   task automatic step();
      @(posedge clk);
      model_update();
      #1;
      compare_all();
      if (coin_out != 2'b00) pay_seq = pay_seq * 100 + cents(coin_out);
      led_seen |= led_vend;
      tick = 0; coin_valid = 0; vend_req = 0; cancel = 0;
   endtask

   task automatic do_tick();
      tick = 1; step();
   endtask

   task automatic coin(input logic [1:0] t);
      coin_valid = 1; coin_type = t; step();
   endtask

   task automatic vend(input logic [3:0] s);
      sel = s; vend_req = 1; step();
   endtask

   task automatic drain();
      for (int i = 0; i < 100 && m_mode != M_IDLE; i++) do_tick();
      chk("drain_busy", busy, 0);
      chk("drain_credit", credit, 0);
   endtask

   initial begin
      // reset with random activity on the inputs
      clr = 0;
      for (int i = 0; i < 5; i++) begin
         tick = 1'($urandom); coin_valid = 1'($urandom); coin_type = 2'($urandom);
         sel = 4'($urandom); vend_req = 1'($urandom); cancel = 1'($urandom);
         step();
      end
      chk("reset_credit", credit, 0);
      chk("reset_busy", busy, 0);
      clr = 1; step();

      // 25 + 10, buy product 0, change 10 + 10
      coin(2'b10); coin(2'b01);
      chk("s1_credit35", credit, 35);
      vend(4'b0001);
      chk("s1_credit20", credit, 20);
      chk("s1_led", led_vend, 4'b0001);
      do_tick(); do_tick();
      chk("s1_led_held", led_vend, 4'b0001);
      do_tick();
      chk("s1_led_off", led_vend, 0);
      chk("s1_busy_change", busy, 1);
      pay_seq = 0;
      do_tick(); step(); do_tick();
      chk("s1_payout", pay_seq, 1010);
      chk("s1_credit0", credit, 0);
      chk("s1_idle", busy, 0);

      // insufficient credit and non-one-hot select
      coin(2'b01);
      vend(4'b0100);
      chk("s2_deny_price", deny, 1);
      chk("s2_credit10", credit, 10);
      coin(2'b10); coin(2'b01); coin(2'b00);
      vend(4'b0011);
      chk("s2_deny_sel", deny, 1);
      chk("s2_credit50", credit, 50);
      cancel = 1; step();
      drain();

      // ceiling and illegal coin
      coin(2'b10); coin(2'b10); coin(2'b10); coin(2'b01); coin(2'b00);
      chk("s3_credit90", credit, 90);
      coin(2'b01);
      chk("s3_reject_ceiling", coin_reject, 1);
      chk("s3_credit_held", credit, 90);
      coin(2'b11);
      chk("s3_reject_illegal", coin_reject, 1);
      cancel = 1; step();
      drain();

      // cancel beats vend on the same clock
      coin(2'b10); coin(2'b01); coin(2'b00);
      sel = 4'b0001; cancel = 1; vend_req = 1; step();
      chk("s4_busy", busy, 1);
      pay_seq = 0; led_seen = 0;
      drain();
      chk("s4_payout", pay_seq, 251005);
      chk("s4_no_led", led_seen, 0);

      // idle timeout refunds 5c
      coin(2'b00);
      for (int i = 1; i <= 500; i++) begin
         do_tick();
         if (i == 499) chk("s5_before_timeout", busy, 0);
      end
      chk("s5_timeout_change", busy, 1);
      pay_seq = 0;
      do_tick();
      chk("s5_payout", pay_seq, 5);
      chk("s5_idle", busy, 0);

      // reset during change payout
      coin(2'b10); coin(2'b10);
      cancel = 1; step();
      do_tick();
      chk("s6_first_coin", coin_out, 2'b11);
      clr = 0; tick = 1; step();
      chk("s6_credit", credit, 0);
      chk("s6_coin_out", coin_out, 0);
      chk("s6_busy", busy, 0);
      clr = 1; step();

      // random traffic
      for (int i = 0; i < 4000; i++) begin
         tick       = ($urandom_range(0, 2) == 0);
         coin_valid = ($urandom_range(0, 3) == 0);
         coin_type  = 2'($urandom);
         vend_req   = ($urandom_range(0, 9) == 0);
         cancel     = ($urandom_range(0, 40) == 0);
         if ($urandom_range(0, 7) == 0) sel = 4'($urandom);
         else sel = 4'(1 << $urandom_range(0, 3));
         clr        = ($urandom_range(0, 499) != 0);
         step();
      end
      clr = 1; step();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
